// File: rtl/tlul_mem_arbiter.sv
// tlul_mem_arbiter: round-robin arbiter that lets NumHosts TL-UL hosts share a
// single in-order main-memory TL-UL device. The A channel is granted with zero
// added latency. Each accepted request's host index goes into an ID FIFO, and
// the FIFO head steers the D channel back to the host that issued it.
//
// Ports
//   clk_i         : clock, rising edge
//   rst_i         : synchronous active-high reset
//   host_req_i    : per-host TL-UL requests (A channel + d_ready)
//   host_rsp_o    : per-host TL-UL responses (D channel + a_ready)
//   mem_req_o     : request to the memory device
//   mem_rsp_i     : response from the memory device
//   outstanding_o : number of accepted requests still waiting for a D response
//   err_o         : sticky; set when a D response arrives with nothing in flight

package tlul_pkg;
  localparam int unsigned SrcW  = 8;
  localparam int unsigned AddrW = 32;
  localparam int unsigned DataW = 32;
  localparam int unsigned MaskW = DataW / 8;

  typedef struct packed {
    logic             a_valid;
    logic [2:0]       a_opcode;
    logic [2:0]       a_param;
    logic [1:0]       a_size;
    logic [SrcW-1:0]  a_source;
    logic [AddrW-1:0] a_address;
    logic [MaskW-1:0] a_mask;
    logic [DataW-1:0] a_data;
    logic             d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic             d_valid;
    logic [2:0]       d_opcode;
    logic [2:0]       d_param;
    logic [1:0]       d_size;
    logic [SrcW-1:0]  d_source;
    logic             d_sink;
    logic [DataW-1:0] d_data;
    logic             d_error;
    logic             a_ready;
  } tl_d2h_t;
endpackage

module tlul_mem_arbiter #(
  parameter int unsigned NumHosts       = 4,
  parameter int unsigned MaxOutstanding = 4
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  tlul_pkg::tl_h2d_t                   host_req_i [NumHosts],
  output tlul_pkg::tl_d2h_t                   host_rsp_o [NumHosts],
  output tlul_pkg::tl_h2d_t                   mem_req_o,
  input  tlul_pkg::tl_d2h_t                   mem_rsp_i,
  output logic [$clog2(MaxOutstanding+1)-1:0] outstanding_o,
  output logic                                err_o
);

  localparam int unsigned IdxW = $clog2(NumHosts);
  localparam int unsigned PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
  localparam int unsigned CntW = $clog2(MaxOutstanding + 1);

  typedef enum logic {IDLE, LOCKED} state_e;

  state_e          state_q, state_d;
  logic [IdxW-1:0] rr_ptr_q, lock_idx_q;
  logic [IdxW-1:0] arb_idx, winner, head;
  logic [IdxW:0]   cand_sum;
  logic [IdxW-1:0] cand_idx;
  logic            arb_found, grant;
  logic            a_hs, d_hs, d_drop;
  logic            full, empty;

  logic [IdxW-1:0] id_fifo_q [MaxOutstanding];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] cnt_q;

  // Pointer increment that wraps at the (possibly non-power-of-two) depth.
  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(MaxOutstanding - 1)) ? '0 : p + PtrW'(1);
  endfunction

  assign full          = (cnt_q == CntW'(MaxOutstanding));
  assign empty         = (cnt_q == '0);
  assign head          = id_fifo_q[rd_ptr_q];
  assign outstanding_o = cnt_q;

  assign a_hs   = grant && mem_rsp_i.a_ready;
  assign d_hs   = !rst_i && !empty && mem_rsp_i.d_valid && host_req_i[head].d_ready;
  assign d_drop = !rst_i && empty && mem_rsp_i.d_valid;

  // Round-robin search: first requesting host at or after rr_ptr.
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = '0;
    cand_sum  = '0;
    cand_idx  = '0;
    for (int unsigned k = 0; k < NumHosts; k++) begin
      cand_sum = {1'b0, rr_ptr_q} + (IdxW+1)'(k);
      if (cand_sum >= (IdxW+1)'(NumHosts)) begin
        cand_sum = cand_sum - (IdxW+1)'(NumHosts);
      end
      cand_idx = IdxW'(cand_sum);
      if (!arb_found && host_req_i[cand_idx].a_valid) begin
        arb_found = 1'b1;
        arb_idx   = cand_idx;
      end
    end
  end

  // Grant FSM: state register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Grant FSM: next state. LOCKED pins the winner while a_ready is low.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (grant && !mem_rsp_i.a_ready) state_d = LOCKED;
      LOCKED:  if (!grant || mem_rsp_i.a_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Grant FSM: outputs and channel steering.
  always_comb begin
    winner = arb_idx;
    grant  = arb_found;
    if (state_q == LOCKED) begin
      winner = lock_idx_q;
      grant  = host_req_i[lock_idx_q].a_valid;
    end
    if (full || rst_i) begin
      grant = 1'b0;
    end

    mem_req_o = '0;
    if (grant) begin
      mem_req_o = host_req_i[winner];
    end
    mem_req_o.a_valid = grant;
    // With nothing in flight, stray responses are sunk so the device never stalls.
    mem_req_o.d_ready = !rst_i && (empty || host_req_i[head].d_ready);

    for (int unsigned i = 0; i < NumHosts; i++) begin
      host_rsp_o[i]         = mem_rsp_i;
      host_rsp_o[i].a_ready = grant && (winner == IdxW'(i)) && mem_rsp_i.a_ready;
      host_rsp_o[i].d_valid = !rst_i && !empty && (head == IdxW'(i)) && mem_rsp_i.d_valid;
    end
  end

  // Arbitration pointer, lock holder, FIFO pointers, occupancy and error flag.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_ptr_q   <= '0;
      lock_idx_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      err_o      <= 1'b0;
    end else begin
      if (state_q == IDLE && grant) begin
        lock_idx_q <= winner;
      end
      if (a_hs) begin
        rr_ptr_q <= (winner == IdxW'(NumHosts - 1)) ? '0 : winner + IdxW'(1);
        wr_ptr_q <= ptr_inc(wr_ptr_q);
      end
      if (d_hs) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
      if (a_hs && !d_hs) begin
        cnt_q <= cnt_q + CntW'(1);
      end else if (!a_hs && d_hs) begin
        cnt_q <= cnt_q - CntW'(1);
      end
      if (d_drop) begin
        err_o <= 1'b1;
      end
    end
  end

  // ID FIFO storage; contents are qualified by the occupancy count.
  always_ff @(posedge clk_i) begin
    if (a_hs) begin
      id_fifo_q[wr_ptr_q] <= winner;
    end
  end

endmodule

// File: tb/tb_tlul_mem_arbiter.sv
// Bench for tlul_mem_arbiter: directed scenarios with literal checks. A
// queue-based reference model is checked against the DUT on every negedge.
module tb_tlul_mem_arbiter;
  localparam int N  = 4;
  localparam int MO = 4;

  logic              clk = 1'b0;
  logic              rst;
  tlul_pkg::tl_h2d_t hreq [N];
  tlul_pkg::tl_d2h_t hrsp [N];
  tlul_pkg::tl_h2d_t mreq;
  tlul_pkg::tl_d2h_t mrsp;
  logic [2:0]        outstanding;
  logic              err;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: in-flight host order, next search start, stalled winner.
  int q[$];
  int rr     = 0;
  int held   = -1;
  bit err_m  = 1'b0;

  tlul_mem_arbiter #(.NumHosts(N), .MaxOutstanding(MO)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .host_req_i   (hreq),
    .host_rsp_o   (hrsp),
    .mem_req_o    (mreq),
    .mem_rsp_i    (mrsp),
    .outstanding_o(outstanding),
    .err_o        (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_av(input int h, input bit v);
    hreq[h].a_valid = v;
  endtask

  task automatic set_all_av(input bit v);
    for (int i = 0; i < N; i++) hreq[i].a_valid = v;
  endtask

  // Check DUT outputs against the model, then advance the model to the next edge.
  task automatic model_cycle();
    int  win;
    int  hd;
    bit  pop;
    if (rst) begin
      chk("rst_mem_a_valid", mreq.a_valid, 0);
      chk("rst_mem_d_ready", mreq.d_ready, 0);
      for (int i = 0; i < N; i++) begin
        chk("rst_host_a_ready", hrsp[i].a_ready, 0);
        chk("rst_host_d_valid", hrsp[i].d_valid, 0);
      end
      chk("m_outstanding", outstanding, q.size());
      chk("m_err", err, err_m);
      q.delete();
      rr    = 0;
      held  = -1;
      err_m = 1'b0;
      return;
    end
    win = -1;
    if (q.size() < MO) begin
      if (held >= 0) begin
        if (hreq[held].a_valid) win = held;
      end else begin
        for (int k = 0; k < N; k++) begin
          int c;
          c = (rr + k) % N;
          if (win < 0 && hreq[c].a_valid) win = c;
        end
      end
    end
    hd = (q.size() > 0) ? q[0] : -1;

    chk("m_mem_a_valid", mreq.a_valid, win >= 0);
    if (win >= 0) begin
      chk("m_mem_a_source", mreq.a_source, hreq[win].a_source);
      chk("m_mem_a_address", mreq.a_address, hreq[win].a_address);
      chk("m_mem_a_data", mreq.a_data, hreq[win].a_data);
    end
    for (int i = 0; i < N; i++) begin
      chk("m_host_a_ready", hrsp[i].a_ready, (i == win) && mrsp.a_ready);
      chk("m_host_d_valid", hrsp[i].d_valid, (i == hd) && mrsp.d_valid);
      if (i == hd) chk("m_host_d_data", hrsp[i].d_data, mrsp.d_data);
    end
    chk("m_mem_d_ready", mreq.d_ready, (hd >= 0) ? hreq[hd].d_ready : 1'b1);
    chk("m_outstanding", outstanding, q.size());
    chk("m_err", err, err_m);

    pop = (hd >= 0) && mrsp.d_valid && hreq[hd].d_ready;
    if (hd < 0 && mrsp.d_valid) err_m = 1'b1;
    if (pop) void'(q.pop_front());
    if (win >= 0) begin
      if (mrsp.a_ready) begin
        q.push_back(win);
        rr   = (win + 1) % N;
        held = -1;
      end else begin
        held = win;
      end
    end else begin
      held = -1;
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      model_cycle();
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst  = 1'b1;
    mrsp = '0;
    for (int i = 0; i < N; i++) begin
      hreq[i]           = '0;
      hreq[i].a_source  = 8'(8'h10 + i);
      hreq[i].a_address = 32'(32'h1000 * (i + 1));
      hreq[i].a_data    = 32'(32'hA0 + i);
      hreq[i].d_ready   = 1'b1;
    end
    step();
    step();
    rst = 1'b0;
    #2;
    chk("reset_outstanding", outstanding, 0);
    chk("reset_err", err, 0);
    chk("reset_a_valid", mreq.a_valid, 0);

    // Hosts 0 and 2 together: 0 first, then 2; responses return in that order.
    step(); mrsp.a_ready = 1'b1; set_av(0, 1); set_av(2, 1);
    #2 chk("a_grant0", hrsp[0].a_ready, 1); chk("a_nogrant2", hrsp[2].a_ready, 0);
    chk("a_src0", mreq.a_source, 8'h10);
    step(); set_av(0, 0);
    #2 chk("a_grant2", hrsp[2].a_ready, 1); chk("a_src2", mreq.a_source, 8'h12);
    step(); set_av(2, 0);
    #2 chk("a_outstanding2", outstanding, 2); chk("a_idle", mreq.a_valid, 0);
    step(); mrsp.d_valid = 1'b1; mrsp.d_data = 32'hD0;
    #2 chk("a_d_head0", hrsp[0].d_valid, 1); chk("a_d_not2", hrsp[2].d_valid, 0);
    step(); mrsp.d_data = 32'hD1;
    #2 chk("a_d_head2", hrsp[2].d_valid, 1); chk("a_d_not0", hrsp[0].d_valid, 0);
    step(); mrsp.d_valid = 1'b0;
    #2 chk("a_drained", outstanding, 0);

    // Host 1 stalled by a_ready=0 keeps the port although host 0 would win the search.
    step(); mrsp.a_ready = 1'b0; set_av(1, 1);
    #2 chk("b_src1", mreq.a_source, 8'h11);
    step(); set_av(0, 1);
    #2 chk("b_hold1_c1", mreq.a_source, 8'h11); chk("b_host0_wait", hrsp[0].a_ready, 0);
    step();
    #2 chk("b_hold1_c2", mreq.a_source, 8'h11);
    step(); mrsp.a_ready = 1'b1;
    #2 chk("b_hs1", hrsp[1].a_ready, 1); chk("b_hs1_src", mreq.a_source, 8'h11);
    step(); set_av(1, 0);
    #2 chk("b_grant0", hrsp[0].a_ready, 1); chk("b_src0", mreq.a_source, 8'h10);
    step(); set_av(0, 0);
    #2 chk("b_outstanding2", outstanding, 2);
    step(); mrsp.d_valid = 1'b1; mrsp.d_data = 32'hB1;
    #2 chk("b_d_head1", hrsp[1].d_valid, 1);
    step(); mrsp.d_data = 32'hB0;
    #2 chk("b_d_head0", hrsp[0].d_valid, 1);
    step(); mrsp.d_valid = 1'b0;
    #2 chk("b_drained", outstanding, 0);

    // Five back-to-back requests against a depth-4 FIFO.
    step(); set_all_av(1);
    repeat (4) step();
    #2 chk("c_full_outstanding", outstanding, 4); chk("c_full_blocked", mreq.a_valid, 0);
    step();
    #2 chk("c_still_blocked", mreq.a_valid, 0);
    step(); mrsp.d_valid = 1'b1;
    #2 chk("c_blocked_on_pop", mreq.a_valid, 0); chk("c_pop_ready", mreq.d_ready, 1);
    step(); mrsp.d_valid = 1'b0;
    #2 chk("c_fifth_issued", mreq.a_valid, 1); chk("c_after_pop", outstanding, 3);
    chk("c_fifth_src", mreq.a_source, 8'h11);
    step(); set_all_av(0);
    #2 chk("c_refull", outstanding, 4);
    step(); mrsp.d_valid = 1'b1;
    repeat (4) step();
    mrsp.d_valid = 1'b0;
    #2 chk("c_drained", outstanding, 0);

    // Head host back-pressures the D channel for two cycles.
    step(); set_av(3, 1);
    #2 chk("d_grant3", hrsp[3].a_ready, 1);
    step(); set_av(3, 0); hreq[3].d_ready = 1'b0; mrsp.d_valid = 1'b1; mrsp.d_data = 32'hD3;
    #2 chk("d_dready_low", mreq.d_ready, 0); chk("d_valid_head3", hrsp[3].d_valid, 1);
    chk("d_other_quiet", hrsp[0].d_valid, 0);
    step();
    #2 chk("d_no_pop", outstanding, 1); chk("d_dready_low2", mreq.d_ready, 0);
    step(); hreq[3].d_ready = 1'b1;
    #2 chk("d_dready_high", mreq.d_ready, 1);
    step(); mrsp.d_valid = 1'b0;
    #2 chk("d_popped", outstanding, 0);

    // Unexpected response while empty: sunk, flagged, flag is sticky until reset.
    step(); mrsp.d_valid = 1'b1;
    #2 chk("e_dready_empty", mreq.d_ready, 1); chk("e_no_dvalid", hrsp[0].d_valid, 0);
    chk("e_err_before", err, 0);
    step(); mrsp.d_valid = 1'b0;
    #2 chk("e_err_set", err, 1);
    step(); step();
    #2 chk("e_err_sticky", err, 1);
    rst = 1'b1;
    step(); rst = 1'b0;
    #2 chk("e_err_cleared", err, 0);

    // Simultaneous push and pop leaves the count unchanged.
    step(); set_av(0, 1);
    step(); set_av(0, 0); set_av(1, 1); mrsp.d_valid = 1'b1;
    #2 chk("f_pushpop_before", outstanding, 1);
    step(); set_av(1, 0); mrsp.d_valid = 1'b0;
    #2 chk("f_pushpop_after", outstanding, 1);

    // Reset with three in flight discards tracking and restarts arbitration at host 0.
    step(); set_av(2, 1); set_av(3, 1);
    step(); set_av(2, 0);
    step(); set_av(3, 0);
    #2 chk("g_three", outstanding, 3);
    step(); rst = 1'b1; set_all_av(1); mrsp.d_valid = 1'b1;
    #2 chk("g_rst_a_valid", mreq.a_valid, 0); chk("g_rst_d_ready", mreq.d_ready, 0);
    chk("g_rst_a_ready", hrsp[0].a_ready, 0); chk("g_rst_d_valid", hrsp[1].d_valid, 0);
    step(); rst = 1'b0; mrsp.d_valid = 1'b0;
    #2 chk("g_outstanding_cleared", outstanding, 0); chk("g_rr_reset", hrsp[0].a_ready, 1);
    chk("g_src0", mreq.a_source, 8'h10);
    step(); set_all_av(0); mrsp.d_valid = 1'b1;
    step(); mrsp.d_valid = 1'b0;
    #2 chk("g_drained", outstanding, 0);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tlul_mem_arbiter.md
TLUL_MEM_ARBITER -- requirements
Module: tlul_mem_arbiter

Interface
REQ-001 Parameter NumHosts, default 4, number of TL-UL hosts sharing the main-memory port (2..8).
REQ-002 Parameter MaxOutstanding, default 4, max A-channel requests accepted by the device whose D response has not yet been consumed (1..16).
REQ-003 Port clk_i  in  1  single clock; all logic on rising edge.
REQ-004 Port rst_i  in  1  reset, synchronous and active-high.
REQ-005 Port host_req_i  in  NumHosts x tlul_pkg::tl_h2d_t  per-host requests.
REQ-006 Port host_rsp_o  out  NumHosts x tlul_pkg::tl_d2h_t  per-host responses.
REQ-007 Port mem_req_o  out  tlul_pkg::tl_h2d_t  request to the main-memory TL-UL device.
REQ-008 Port mem_rsp_i  in  tlul_pkg::tl_d2h_t  response from the main-memory device.
REQ-009 Port outstanding_o  out  $clog2(MaxOutstanding+1)  current in-flight count.
REQ-010 Port err_o  out  1  sticky flag: unexpected D response received.

Function
REQ-011 The device SHALL be treated as returning D responses strictly in A-acceptance order; no source remapping is done, a_source passes through unchanged.
REQ-012 Arbitration SHALL be round-robin over hosts with a_valid=1, starting the search at rr_ptr; rr_ptr resets to 0.
REQ-013 Grant state machine SHALL have states IDLE and LOCKED: IDLE with any eligible a_valid selects a winner combinationally and drives its A fields onto mem_req_o the same cycle (zero added latency).
REQ-014 If mem_rsp_i.a_ready=0 while a_valid is driven, the FSM SHALL enter LOCKED and hold the same winner until the A handshake completes (TL-UL valid stability), regardless of other hosts.
REQ-015 On A handshake (mem a_valid && a_ready), rr_ptr SHALL become (winner+1) mod NumHosts, the winner index SHALL be pushed into an ID FIFO of depth MaxOutstanding, and the FSM returns to IDLE.
REQ-016 Only the winner SHALL see host_rsp_o[i].a_ready = mem a_ready; all other hosts see a_ready=0.
REQ-017 When the ID FIFO holds MaxOutstanding entries, mem_req_o.a_valid SHALL be 0 and no host is granted; a pop in the same cycle does not unblock a push until the next cycle.
REQ-018 D channel: host_rsp_o[head].d_valid SHALL equal mem d_valid and carry all D fields; other hosts see d_valid=0; mem_req_o.d_ready SHALL equal host_req_i[head].d_ready.
REQ-019 On D handshake the FIFO head SHALL be popped; simultaneous push and pop keeps count unchanged.
REQ-020 If mem d_valid=1 while the FIFO is empty, mem_req_o.d_ready SHALL be 1 (response dropped), no host sees d_valid, and err_o SHALL be set until reset.
REQ-021 outstanding_o SHALL equal the FIFO occupancy, registered, updated the cycle after push/pop.
REQ-022 FIFO pointers SHALL wrap modulo MaxOutstanding; non-power-of-two depths SHALL be supported.

Reset
REQ-023 While rst_i=1 at a clock edge: FSM=IDLE, rr_ptr=0, FIFO empty, outstanding_o=0, err_o=0.
REQ-024 During reset all outputs SHALL be: mem a_valid=0, mem d_ready=0, all host a_ready=0, all host d_valid=0.
REQ-025 Reset mid-transaction SHALL discard all in-flight tracking; the device is required to be reset concurrently.

Verification
REQ-026 Hosts 0,2 assert a_valid together, a_ready=1 -> host 0 granted cycle 0, host 2 cycle 1, FIFO order {0,2}, outstanding_o=2.
REQ-027 Host 1 a_valid, a_ready=0 for 3 cycles while host 0 raises a_valid -> mem A fields stay host 1's until handshake, host 0 granted next.
REQ-028 MaxOutstanding=4, 5 back-to-back requests, no D responses -> 4 accepted, 5th a_valid held 0 until first D handshake, then issued the following cycle.
REQ-029 Responses with head host d_ready=0 for 2 cycles -> mem d_ready=0, no pop, other hosts d_valid=0; pop on handshake.
REQ-030 mem d_valid=1 with empty FIFO -> d_ready=1, err_o=1 next cycle and stays 1; reset clears it.
REQ-031 rst_i asserted with 3 outstanding -> next cycle outstanding_o=0, rr_ptr=0, all valid/ready outputs 0.
